// File: rtl/wb_bus_master.sv
// Wishbone pipelined bus master fed by the UART command word stream.
// One outstanding transaction; every accepted command except non-abort
// SPECIAL ops produces exactly one response word.
//
// state | meaning
// IDLE  | no bus cycle open, commands accepted
// REQ   | cyc and stb high, waiting for the slave to take the request
// WAIT  | request taken, cyc high, waiting for ack/err/timeout
module wb_bus_master #(
   parameter int DW      = 32,
   parameter int AW      = 30,
   parameter int TIMEOUT = 1023
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_cmd_stb,
   input  logic [DW+1:0]   i_cmd_word,
   output logic            o_cmd_busy,
   output logic            o_rsp_stb,
   output logic [DW+1:0]   o_rsp_word,
   output logic            o_wb_cyc,
   output logic            o_wb_stb,
   output logic            o_wb_we,
   output logic [AW-1:0]   o_wb_addr,
   output logic [DW-1:0]   o_wb_data,
   output logic [DW/8-1:0] o_wb_sel,
   input  logic            i_wb_stall,
   input  logic            i_wb_ack,
   input  logic            i_wb_err,
   input  logic [DW-1:0]   i_wb_data
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   localparam logic [1:0] CMD_READ    = 2'b00;
   localparam logic [1:0] CMD_WRITE   = 2'b01;
   localparam logic [1:0] CMD_ADDR    = 2'b10;
   localparam logic [1:0] CMD_SPECIAL = 2'b11;

   localparam logic [2:0] OP_RESET    = 3'd0;
   localparam logic [2:0] OP_BUS_ERR  = 3'd1;
   localparam logic [2:0] OP_TIMEOUT  = 3'd2;

   localparam logic [DW+1:0] RSP_RESET   = {2'b11, OP_RESET,   {(DW-3){1'b0}}};
   localparam logic [DW+1:0] RSP_BUS_ERR = {2'b11, OP_BUS_ERR, {(DW-3){1'b0}}};
   localparam logic [DW+1:0] RSP_TIMEOUT = {2'b11, OP_TIMEOUT, {(DW-3){1'b0}}};
   localparam logic [DW+1:0] RSP_ACK     = {2'b01, {DW{1'b0}}};

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t          state, state_nxt;
   logic [TW-1:0]   timer, timer_nxt;
   logic [AW-1:0]   addr, addr_nxt;
   logic [DW-1:0]   data, data_nxt;
   logic            we, we_nxt;
   logic            inc_en, inc_en_nxt;
   logic            rst_pend;
   logic            rsp_stb, rsp_stb_nxt;
   logic [DW+1:0]   rsp_word, rsp_word_nxt;

   logic [1:0]      cmd_code;
   logic [DW-1:0]   payload;
   logic [2:0]      special_op;
   logic            busy;
   logic            accept;
   logic            abort;

   assign cmd_code   = i_cmd_word[DW+1:DW];
   assign payload    = i_cmd_word[DW-1:0];
   assign special_op = payload[DW-1:DW-3];

   assign busy   = (state != IDLE);
   assign accept = i_cmd_stb && !busy;
   // Abort bypasses busy so a hung or slow transaction can always be killed.
   assign abort  = i_cmd_stb && (cmd_code == CMD_SPECIAL) && (special_op == OP_RESET);

   assign o_cmd_busy = busy;
   assign o_wb_cyc   = busy;
   assign o_wb_stb   = (state == REQ);
   assign o_wb_we    = we;
   assign o_wb_addr  = addr;
   assign o_wb_data  = data;
   assign o_wb_sel   = '1;
   assign o_rsp_stb  = rsp_stb;
   assign o_rsp_word = rsp_word;

   // Next-state, bus and response decisions for the coming edge.
   always_comb begin
      state_nxt    = state;
      timer_nxt    = timer;
      addr_nxt     = addr;
      data_nxt     = data;
      we_nxt       = we;
      inc_en_nxt   = inc_en;
      rsp_stb_nxt  = 1'b0;
      rsp_word_nxt = rsp_word;

      // The post-reset announcement shares the RESET code with abort, so a
      // coincident abort still yields a single identical response.
      if (rst_pend) begin
         rsp_stb_nxt  = 1'b1;
         rsp_word_nxt = RSP_RESET;
      end

      if (abort) begin
         state_nxt    = IDLE;
         we_nxt       = 1'b0;
         rsp_stb_nxt  = 1'b1;
         rsp_word_nxt = RSP_RESET;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  case (cmd_code)
                     CMD_READ: begin
                        state_nxt = REQ;
                        we_nxt    = 1'b0;
                        timer_nxt = '0;
                     end
                     CMD_WRITE: begin
                        state_nxt = REQ;
                        we_nxt    = 1'b1;
                        data_nxt  = payload;
                        timer_nxt = '0;
                     end
                     CMD_ADDR: begin
                        addr_nxt     = payload[AW-1:0];
                        inc_en_nxt   = !payload[AW];
                        rsp_stb_nxt  = 1'b1;
                        rsp_word_nxt = {CMD_ADDR, payload};
                     end
                     default: ;
                  endcase
               end
            end
            REQ, WAIT: begin
               // ack may arrive while still stalled in REQ; it still ends the cycle.
               if (i_wb_err || i_wb_ack || (timer == TIMER_LAST)) begin
                  state_nxt   = IDLE;
                  we_nxt      = 1'b0;
                  rsp_stb_nxt = 1'b1;
                  if (i_wb_err) begin
                     rsp_word_nxt = RSP_BUS_ERR;
                  end else if (i_wb_ack) begin
                     rsp_word_nxt = we ? RSP_ACK : {2'b00, i_wb_data};
                     if (inc_en) begin
                        addr_nxt = addr + AW'(1);
                     end
                  end else begin
                     rsp_word_nxt = RSP_TIMEOUT;
                  end
               end else begin
                  timer_nxt = timer + TW'(1);
                  if ((state == REQ) && !i_wb_stall) begin
                     state_nxt = WAIT;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State and datapath registers; reset arms the one-shot RESET response.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= IDLE;
         timer    <= '0;
         addr     <= '0;
         data     <= '0;
         we       <= 1'b0;
         inc_en   <= 1'b1;
         rst_pend <= 1'b1;
         rsp_stb  <= 1'b0;
         rsp_word <= '0;
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         addr     <= addr_nxt;
         data     <= data_nxt;
         we       <= we_nxt;
         inc_en   <= inc_en_nxt;
         rst_pend <= 1'b0;
         rsp_stb  <= rsp_stb_nxt;
         rsp_word <= rsp_word_nxt;
      end
   end

endmodule
